// File: rtl/hbridge_gate_sequencer.sv
// hbridge_gate_sequencer: NUM_CH H-bridge switch sequencer with decay modes and dead time on every turn-on.
// Optional fault latch (Fault_n, FaultClr, fault_latched) is compiled in with GATE_FAULT_LATCH_EN.
module hbridge_gate_sequencer #(
  parameter int NUM_CH      = 1,
  parameter int DEAD_CYCLES = 8,
  parameter int DT_W        = 8
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Enable,
  input  logic [1:0]          Mode,
  input  logic [NUM_CH-1:0]   PWM,
  input  logic [NUM_CH-1:0]   direction,
`ifdef GATE_FAULT_LATCH_EN
  input  logic                Fault_n,
  input  logic                FaultClr,
  output logic                fault_latched,
`endif
  output logic [4*NUM_CH-1:0] signals,
  output logic [NUM_CH-1:0]   busy
);
  localparam logic [DT_W-1:0] DT = DT_W'(DEAD_CYCLES);
  typedef enum logic {ON, DEAD} state_t;
  logic              en_r;
  logic [1:0]        mode_r;
  logic [NUM_CH-1:0] pwm_r, dir_r;
  logic              kill;
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) {en_r, mode_r, pwm_r, dir_r} <= '0;
    else {en_r, mode_r, pwm_r, dir_r} <= {Enable, Mode, PWM, direction};
`ifdef GATE_FAULT_LATCH_EN
  logic [1:0] f_sync;
  // Synchroniser idles high so reset does not look like a fault
  always_ff @(posedge Clock or negedge Reset_n)
    if (!Reset_n) begin
      f_sync        <= 2'b11;
      fault_latched <= 1'b0;
    end else begin
      f_sync        <= {f_sync[0], Fault_n};
      fault_latched <= !f_sync[1] | (fault_latched & !FaultClr);
    end
  assign kill = !f_sync[1] | fault_latched;
`else
  assign kill = 1'b0;
`endif
  function automatic logic [3:0] pattern(input logic en, input logic [1:0] m, input logic p, input logic d);
    return !en ? 4'b0000 :
           p ? (d ? 4'b0110 : 4'b1001) :
           m == 2'd0 ? 4'b0000 :
           m == 2'd1 ? 4'b0101 :
           m == 2'd2 ? 4'b1010 :
           (d ? 4'b0100 : 4'b0001);
  endfunction
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t          st, st_n;
    logic [3:0]      cur, cur_n, hold, hold_n, tgt;
    logic [DT_W-1:0] cnt, cnt_n;
    logic            rising;
    assign tgt    = pattern(en_r, mode_r, pwm_r[c], dir_r[c]);
    assign rising = |(tgt & ~cur);
    always_comb begin
      st_n   = st;
      cur_n  = cur;
      cnt_n  = cnt;
      hold_n = hold;
      if (st == ON) begin
        if (tgt != cur) begin
          if (!rising || DEAD_CYCLES == 0) cur_n = tgt;
          else begin
            cur_n  = cur & tgt;
            cnt_n  = DT;
            hold_n = tgt;
            st_n   = DEAD;
          end
        end
      end else if (tgt != hold) begin
        // A new target mid dead-time either completes at once or restarts the wait
        if (!rising) begin
          cur_n = tgt;
          st_n  = ON;
        end else begin
          cur_n  = cur & tgt;
          cnt_n  = DT;
          hold_n = tgt;
        end
      end else if (cnt == DT_W'(1)) begin
        cur_n = tgt;
        st_n  = ON;
      end else cnt_n = cnt - DT_W'(1);
      if (kill) begin
        st_n  = ON;
        cur_n = 4'b0000;
        cnt_n = '0;
      end
    end
    always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) begin
        st   <= ON;
        cur  <= 4'b0000;
        cnt  <= '0;
        hold <= 4'b0000;
      end else begin
        st   <= st_n;
        cur  <= cur_n;
        cnt  <= cnt_n;
        hold <= hold_n;
      end
    assign signals[4*c+:4] = cur;
    assign busy[c]         = st == DEAD;
  end
endmodule

// File: tb/tb_hbridge_gate_sequencer.sv
// tb_hbridge_gate_sequencer: randomized and directed checks against a cycle-level behavioural model.
module tb_hbridge_gate_sequencer;
  localparam int NCH = 2;
  localparam int D   = 4;
  logic             Clock, Reset_n, Enable;
  logic [1:0]       Mode;
  logic [NCH-1:0]   PWM, direction;
  logic [4*NCH-1:0] signals;
  logic [NCH-1:0]   busy;
  int total = 0, bad = 0, n = 0;
  logic [3:0]       mo [NCH];
  logic [3:0]       pt [NCH];
  bit               pend [NCH];
  int               since [NCH];
  logic             r_en;
  logic [1:0]       r_mode;
  logic [NCH-1:0]   r_pwm, r_dir;
  logic [4*NCH-1:0] exp_sig;
  logic [NCH-1:0]   exp_busy;

  hbridge_gate_sequencer #(.NUM_CH(NCH), .DEAD_CYCLES(D), .DT_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Mode(Mode),
    .PWM(PWM), .direction(direction), .signals(signals), .busy(busy)
  );

  initial Clock = 0;
  always #5 Clock = ~Clock;

  function automatic logic [3:0] pat(input logic en, input logic [1:0] m, input logic p, input logic d);
    logic [3:0] decay [4];
    decay = '{4'b0000, 4'b0101, 4'b1010, d ? 4'b0100 : 4'b0001};
    if (!en) return 4'b0000;
    if (p) return d ? 4'b0110 : 4'b1001;
    return decay[m];
  endfunction

  function automatic bit shoot_through(input logic [4*NCH-1:0] s);
    for (int c = 0; c < NCH; c++)
      if ((s[4*c+3] & s[4*c+2]) | (s[4*c+1] & s[4*c])) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mo[c] = 4'b0000;
      pt[c] = 4'b0000;
      pend[c] = 0;
      since[c] = 0;
    end
    {r_en, r_mode, r_pwm, r_dir} = '0;
    exp_sig = '0;
    exp_busy = '0;
  endtask

  // Falling bits drop on the first edge that sees the new target; rising bits wait
  // until the target has been stable for D edges, restarting whenever it changes.
  task automatic step();
    @(posedge Clock);
    n++;
    if (!Reset_n) model_reset();
    else begin
      for (int c = 0; c < NCH; c++) begin
        logic [3:0] t;
        t = pat(r_en, r_mode, r_pwm[c], r_dir[c]);
        if ((t & ~mo[c]) == 4'b0000) begin
          mo[c] = t;
          pend[c] = 0;
        end else if (!pend[c] || t != pt[c]) begin
          mo[c] = mo[c] & t;
          pend[c] = 1;
          pt[c] = t;
          since[c] = n;
        end else if (n - since[c] == D) begin
          mo[c] = t;
          pend[c] = 0;
        end
      end
      r_en = Enable;
      r_mode = Mode;
      r_pwm = PWM;
      r_dir = direction;
    end
    #1;
    for (int c = 0; c < NCH; c++) begin
      exp_sig[4*c+:4] = mo[c];
      exp_busy[c] = pend[c];
    end
  endtask

  task automatic test_reset();
    Reset_n = 0;
    Enable = 1;
    Mode = 2'd1;
    PWM = '0;
    direction = '0;
    model_reset();
    #2;
    total++;
    if (signals !== '0 || busy !== '0) begin
      bad++;
      $display("FAIL reset_async got sig=%b busy=%b want sig=0 busy=0", signals, busy);
    end
    repeat (2) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy}) begin
        bad++;
        $display("FAIL reset_hold got sig=%b busy=%b want sig=%b busy=%b", signals, busy, exp_sig, exp_busy);
      end
    end
    Reset_n = 1;
    repeat (8) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy}) begin
        bad++;
        $display("FAIL reset_release got sig=%b busy=%b want sig=%b busy=%b", signals, busy, exp_sig, exp_busy);
      end
    end
  endtask

  task automatic test_turn_on();
    Enable = 1;
    Mode = 2'd1;
    PWM = 2'b10;
    direction = 2'b10;
    repeat (10) step();
    PWM[0] = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy}) begin
        bad++;
        $display("FAIL turn_on i=%0d got sig=%b busy=%b want sig=%b busy=%b", i, signals, busy, exp_sig, exp_busy);
      end
      total++;
      if (signals[7:4] !== 4'b0110 || busy[1] !== 1'b0) begin
        bad++;
        $display("FAIL turn_on_ch1 i=%0d got %b/%b want 0110/0", i, signals[7:4], busy[1]);
      end
      if (i == 2 || i == 6) begin
        total++;
        if (signals[3:0] !== (i == 2 ? 4'b0001 : 4'b1001)) begin
          bad++;
          $display("FAIL turn_on_edge i=%0d got %b want %b", i, signals[3:0], i == 2 ? 4'b0001 : 4'b1001);
        end
      end
    end
  endtask

  task automatic test_reverse();
    direction[0] = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy} || shoot_through(signals)) begin
        bad++;
        $display("FAIL reverse i=%0d got sig=%b busy=%b want sig=%b busy=%b", i, signals, busy, exp_sig, exp_busy);
      end
      if (i == 2 || i == 6) begin
        total++;
        if (signals[3:0] !== (i == 2 ? 4'b0000 : 4'b0110)) begin
          bad++;
          $display("FAIL reverse_edge i=%0d got %b want %b", i, signals[3:0], i == 2 ? 4'b0000 : 4'b0110);
        end
      end
    end
  endtask

  task automatic test_abort();
    Mode = 2'd0;
    PWM[0] = 0;
    direction[0] = 0;
    repeat (8) step();
    PWM[0] = 1;
    repeat (3) step();
    PWM[0] = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy}) begin
        bad++;
        $display("FAIL abort i=%0d got sig=%b busy=%b want sig=%b busy=%b", i, signals, busy, exp_sig, exp_busy);
      end
      if (i == 1 || i == 2) begin
        total++;
        if (signals[3:0] !== 4'b0000 || busy[0] !== (i == 1)) begin
          bad++;
          $display("FAIL abort_edge i=%0d got %b/%b want 0000/%0d", i, signals[3:0], busy[0], i == 1);
        end
      end
    end
  endtask

  task automatic test_mode_sweep();
    logic [3:0] want [4];
    want = '{4'b0000, 4'b0101, 4'b1010, 4'b0100};
    PWM[0] = 0;
    direction[0] = 1;
    for (int m = 0; m < 4; m++) begin
      Mode = 2'(m);
      repeat (7) begin
        step();
        total++;
        if ({signals, busy} !== {exp_sig, exp_busy} || shoot_through(signals)) begin
          bad++;
          $display("FAIL mode_sweep m=%0d got sig=%b busy=%b want sig=%b busy=%b", m, signals, busy, exp_sig, exp_busy);
        end
      end
      total++;
      if (signals[3:0] !== want[m]) begin
        bad++;
        $display("FAIL mode_pattern m=%0d got %b want %b", m, signals[3:0], want[m]);
      end
    end
  endtask

  task automatic test_enable();
    PWM = 2'b11;
    direction = 2'b10;
    repeat (7) step();
    Enable = 0;
    repeat (2) step();
    total++;
    if (signals !== '0 || busy !== '0) begin
      bad++;
      $display("FAIL enable_off got sig=%b busy=%b want sig=0 busy=0", signals, busy);
    end
    Enable = 1;
    repeat (7) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy}) begin
        bad++;
        $display("FAIL enable_on got sig=%b busy=%b want sig=%b busy=%b", signals, busy, exp_sig, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid_dead();
    Mode = 2'd0;
    PWM[0] = 0;
    direction[0] = 0;
    repeat (4) step();
    PWM[0] = 1;
    repeat (3) step();
    total++;
    if (busy[0] !== 1'b1) begin
      bad++;
      $display("FAIL mid_dead_setup got busy=%b want busy[0]=1", busy);
    end
    #1 Reset_n = 0;
    #1;
    model_reset();
    total++;
    if (signals !== '0 || busy !== '0) begin
      bad++;
      $display("FAIL mid_dead_reset got sig=%b busy=%b want sig=0 busy=0", signals, busy);
    end
    step();
    Reset_n = 1;
    repeat (8) begin
      step();
      total++;
      if ({signals, busy} !== {exp_sig, exp_busy}) begin
        bad++;
        $display("FAIL mid_dead_after got sig=%b busy=%b want sig=%b busy=%b", signals, busy, exp_sig, exp_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 80; s++) begin
      Enable = $urandom_range(0, 7) != 0;
      Mode = 2'($urandom_range(0, 3));
      PWM = NCH'($urandom);
      direction = NCH'($urandom);
      repeat ($urandom_range(1, 7)) begin
        step();
        total++;
        if ({signals, busy} !== {exp_sig, exp_busy} || shoot_through(signals)) begin
          bad++;
          $display("FAIL random seg=%0d got sig=%b busy=%b want sig=%b busy=%b", s, signals, busy, exp_sig, exp_busy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_turn_on();
    test_reverse();
    test_abort();
    test_mode_sweep();
    test_enable();
    test_reset_mid_dead();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
